// File: rtl/rv_pkg.sv
// Shared fetch-path definitions: FSM state encoding, reset constants and
// RISC-V instruction field bit positions.
package rv_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

endpackage

// File: rtl/pc_next.sv
// Next-PC logic: sequential increment, branch-target select and target
// alignment check, purely combinational.
module pc_next
    import rv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        next_pc_src,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_target,
    output logic        misalign
);

    // Plain 32-bit add: 0xFFFF_FFFC wraps to 0 without any error.
    assign pc_plus4  = pc + PC_STEP;
    assign pc_target = next_pc_src ? branch_target : pc_plus4;
    assign misalign  = next_pc_src && (branch_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for read data, hold the
// registered instruction until retired, then advance the PC.
//
// state   | meaning
// S_REQ   | issue one-cycle imem read at PC
// S_WAIT  | wait for imem_rvalid, capture rdata
// S_VALID | instruction presented, hold until inst_ready
// S_ERR   | misaligned branch target seen, absorbing until reset
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        NextPCSrc,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] Instruction,
    output logic [6:0]  OpCode,
    output logic [2:0]  Funct3,
    output logic [6:0]  Funct7,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic [4:0]  Rd,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        misalign_err
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        err_q;

    logic        capture;
    logic        retire;
    logic        set_err;
    logic [31:0] pc_plus4;
    logic [31:0] pc_target;
    logic        misalign;

    pc_next u_pc_next (
        .pc            (pc_q),
        .next_pc_src   (NextPCSrc),
        .branch_target (BranchTarget),
        .pc_plus4      (pc_plus4),
        .pc_target     (pc_target),
        .misalign      (misalign)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_REQ: begin
                imem_req   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    if (misalign) begin
                        set_err    = 1'b1;
                        state_next = S_ERR;
                    end else begin
                        retire     = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
        // The state register already sits in S_REQ while rst_n is still low;
        // keep the bus quiet until the first cycle out of reset.
        if (!rst_n) begin
            imem_req   = 1'b0;
            inst_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            err_q   <= 1'b0;
        end else begin
            if (capture) begin
                instr_q <= imem_rdata;
            end
            if (retire) begin
                pc_q <= pc_target;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign imem_addr    = pc_q;
    assign PC           = pc_q;
    assign PCPlus4      = pc_plus4;
    assign Instruction  = instr_q;
    assign misalign_err = err_q;

    assign OpCode = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign Rd     = instr_q[RD_MSB:RD_LSB];
    assign Funct3 = instr_q[FUNCT3_MSB:FUNCT3_LSB];
    assign Rs1    = instr_q[RS1_MSB:RS1_LSB];
    assign Rs2    = instr_q[RS2_MSB:RS2_LSB];
    assign Funct7 = instr_q[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; the bench plays the role of
// instruction memory and the downstream consumer.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        NextPCSrc;
    logic [31:0] BranchTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] Instruction;
    logic [6:0]  OpCode;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  Rd;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        misalign_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .NextPCSrc    (NextPCSrc),
        .BranchTarget (BranchTarget),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .Instruction  (Instruction),
        .OpCode       (OpCode),
        .Funct3       (Funct3),
        .Funct7       (Funct7),
        .Rs1          (Rs1),
        .Rs2          (Rs2),
        .Rd           (Rd),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in the cycle where the request should be visible.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int delay);
        check("req_pulse", {31'd0, imem_req}, 32'd1);
        check("req_addr", imem_addr, addr);
        step();
        for (int i = 1; i < delay; i++) begin
            check("wait_no_req", {31'd0, imem_req}, 32'd0);
            check("wait_no_valid", {31'd0, inst_valid}, 32'd0);
            step();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check("valid", {31'd0, inst_valid}, 32'd1);
        check("instr", Instruction, data);
        check("pc", PC, addr);
        check("pc_plus4", PCPlus4, addr + 32'd4);
    endtask

    task automatic retire(input logic src, input logic [31:0] target);
        NextPCSrc    = src;
        BranchTarget = target;
        inst_ready   = 1'b1;
        step();
        inst_ready   = 1'b0;
        NextPCSrc    = 1'b0;
        BranchTarget = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0, c1, c2;
        rst_n        = 1'b0;
        NextPCSrc    = 1'b0;
        BranchTarget = 32'h0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        inst_ready   = 1'b0;
        step();
        step();

        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_pc", PC, 32'h0);
        check("rst_instr", Instruction, 32'h0000_0013);
        check("rst_err", {31'd0, misalign_err}, 32'd0);

        rst_n = 1'b1;
        #1;
        c0 = cyc;
        do_fetch(32'h0, 32'h00C5_8533, 1);
        check("opcode", {25'd0, OpCode}, 32'h33);
        check("rd", {27'd0, Rd}, 32'd10);
        check("funct3", {29'd0, Funct3}, 32'd0);
        check("rs1", {27'd0, Rs1}, 32'd11);
        check("rs2", {27'd0, Rs2}, 32'd12);
        check("funct7", {25'd0, Funct7}, 32'd0);
        retire(1'b0, 32'h0);
        c1 = cyc;
        do_fetch(32'h4, 32'h4000_80B3, 1);
        check("funct7_sub", {25'd0, Funct7}, 32'h20);
        check("rd_sub", {27'd0, Rd}, 32'd1);
        retire(1'b0, 32'h0);
        c2 = cyc;
        check("period_01", c1 - c0, 32'd3);
        check("period_12", c2 - c1, 32'd3);

        // Slow memory, stray rvalid while valid, then a 5-cycle stall.
        do_fetch(32'h8, 32'h0011_8193, 3);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("stray_rvalid", Instruction, 32'h0011_8193);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
            check("stall_instr", Instruction, 32'h0011_8193);
            check("stall_pc", PC, 32'h8);
            step();
        end
        retire(1'b0, 32'h0);

        do_fetch(32'hC, 32'h0000_006F, 1);
        retire(1'b1, 32'h100);
        do_fetch(32'h100, 32'h0000_0013, 2);
        retire(1'b1, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, 32'h0000_0013, 1);
        check("wrap_plus4", PCPlus4, 32'h0);
        retire(1'b0, 32'h0);
        do_fetch(32'h0, 32'h0000_0013, 1);
        check("no_err_wrap", {31'd0, misalign_err}, 32'd0);

        retire(1'b1, 32'h102);
        for (int i = 0; i < 4; i++) begin
            check("err_flag", {31'd0, misalign_err}, 32'd1);
            check("err_no_req", {31'd0, imem_req}, 32'd0);
            check("err_no_valid", {31'd0, inst_valid}, 32'd0);
            check("err_pc", PC, 32'h0);
            step();
        end

        // Reset out of S_ERR, then reset again mid-S_WAIT with a late response.
        rst_n = 1'b0;
        step();
        check("rst2_err", {31'd0, misalign_err}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst2_req", {31'd0, imem_req}, 32'd1);
        check("rst2_addr", imem_addr, 32'h0);
        step();
        check("rst2_wait", {31'd0, inst_valid}, 32'd0);
        rst_n       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check("rst3_valid", {31'd0, inst_valid}, 32'd0);
        check("rst3_req", {31'd0, imem_req}, 32'd0);
        check("rst3_pc", PC, 32'h0);
        check("rst3_instr", Instruction, 32'h0000_0013);
        rst_n = 1'b1;
        #1;
        do_fetch(32'h0, 32'h00A0_0513, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  in  1  the single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 NextPCSrc  in  1  1 = take BranchTarget for the retiring instruction; 0 = sequential PC+4.
REQ-005 BranchTarget  in  32  branch/jump target computed downstream.
REQ-006 imem_req  out  1  instruction-memory read request, one-cycle pulse.
REQ-007 imem_addr  out  32  word address of request; equals PC.
REQ-008 imem_rvalid  in  1  read data valid, any cycle >=1 after imem_req.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 inst_valid  out  1  decoded instruction fields valid.
REQ-011 inst_ready  in  1  downstream accepts the current instruction (retire).
REQ-012 Instruction  out  32  registered instruction word.
REQ-013 OpCode 7, Funct3 3, Funct7 7, Rs1 5, Rs2 5, Rd 5  out  fields of Instruction: [6:0], [14:12], [31:25], [19:15], [24:20], [11:7].
REQ-014 PC  out  32  address of Instruction; PCPlus4  out  32  PC+4.
REQ-015 misalign_err  out  1  sticky error: target not 4-byte aligned.

Function
REQ-016 FSM states SHALL be S_REQ, S_WAIT, S_VALID, S_ERR.
REQ-017 S_REQ: imem_req=1, imem_addr=PC for exactly one cycle; next state S_WAIT.
REQ-018 S_WAIT: hold until imem_rvalid=1; then capture imem_rdata into Instruction and enter S_VALID.
REQ-019 imem_rvalid outside S_WAIT SHALL be ignored; Instruction not modified.
REQ-020 S_VALID: inst_valid=1; Instruction, fields and PC stable until inst_ready=1.
REQ-021 On S_VALID with inst_ready=1: PC <= (NextPCSrc ? BranchTarget : PC+4); next state S_REQ.
REQ-022 If NextPCSrc=1 and BranchTarget[1:0]!=2'b00 on retire: PC unchanged, misalign_err=1, enter S_ERR.
REQ-023 S_ERR: absorbing until reset; imem_req=0, inst_valid=0.
REQ-024 inst_valid SHALL be 0 in every state except S_VALID.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no error.
REQ-026 Minimum latency: rvalid on cycle after req -> inst_valid 2 cycles after entering S_REQ; throughput max 1 instruction per 3 cycles.
REQ-027 Fields are pure slices of the registered Instruction; no combinational path from imem_rdata to outputs.
REQ-028 One outstanding request maximum; no new imem_req before the previous response is captured.

Reset
REQ-029 On rst_n=0 at a clock edge: PC=RESET_PC, Instruction=32'h0000_0013 (NOP), state=S_REQ, misalign_err=0, inst_valid=0, imem_req=0 that cycle.
REQ-030 Reset mid-S_WAIT or mid-S_VALID SHALL abandon the instruction; imem shares rst_n and drops its pending response.
REQ-031 First imem_req SHALL assert on the first cycle with rst_n=1.

Structure
REQ-032 Shared package rv_pkg: fetch state enum, RESET_PC default, NOP constant, instruction field bit positions.
REQ-033 One sub-module pc_next: combinational PC+4 adder, target mux and alignment check.

Verification
REQ-034 Reset release, rvalid 1 cycle after req, inst_ready=1 always -> imem_addr 0x0,0x4,0x8 on every 3rd cycle.
REQ-035 rdata=32'h00C58533 -> OpCode=7'h33, Rd=10, Funct3=0, Rs1=11, Rs2=12, Funct7=0.
REQ-036 inst_ready=0 for 5 cycles in S_VALID -> outputs constant, no imem_req; then ready -> next req at PC+4.
REQ-037 NextPCSrc=1, BranchTarget=0x100 -> next imem_addr=0x100; BranchTarget=0x102 -> misalign_err=1, no further req.
REQ-038 PC=0xFFFF_FFFC retiring sequentially -> next imem_addr=0x0.
REQ-039 rst_n=0 during S_WAIT with late rvalid -> PC=RESET_PC, inst_valid=0, fresh req on first cycle after reset.
